booth_seq_ctrl: RTL and testbench

Sequential radix-2 Booth control and add/subtract stage for the booths multiplier. It sits directly in front of the 17-bit (2W+1) A:Q:Q-1 shift register and drives that register's load, data, shren and din inputs. It reads the register contents back to pick the Booth action and the sign-fill bit. It accepts a start/operand handshake, runs W add-then-shift iterations, and returns a 2W-bit signed product with a one-cycle done pulse.

---
 rtl/booth_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_booth_seq_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl
// Sequential radix-2 Booth controller and add/subtract stage. It drives an
// external (2W+1)-bit A:Q:Q-1 shift register and reads that register back to
// pick the Booth action and the sign-fill bit for each arithmetic right shift.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   start         request, sampled only in IDLE
//   multiplicand  signed M, captured on start acceptance
//   multiplier    signed Q, captured on start acceptance
//   sr_dout       shift register contents {A, Q, Q-1}
//   sr_load       parallel-load strobe to the shift register
//   sr_data       parallel-load value to the shift register
//   sr_shren      shift-enable strobe to the shift register
//   sr_din        serial-in bit for the shift (sign fill)
//   busy          high from start acceptance until the done pulse
//   done          one-cycle pulse; product valid from this cycle on
//   product       signed 2W-bit result, held until the next done pulse
module booth_seq_ctrl #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     multiplicand,
    input  logic [W-1:0]     multiplier,
    input  logic [2*W:0]     sr_dout,
    output logic             sr_load,
    output logic [2*W:0]     sr_data,
    output logic             sr_shren,
    output logic             sr_din,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   product
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      m_q, m_d;
    logic [W-1:0]      q_q, q_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [2*W-1:0]    product_q, product_d;

    logic              accept;
    logic [CW-1:0]     cnt_inc;
    logic [W-1:0]      a_cur;
    logic [W-1:0]      a_new;

    assign accept  = (state_q == S_IDLE) && start;
    assign cnt_inc = cnt_q + CW'(1);
    assign a_cur   = sr_dout[2*W:W+1];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  state_d = S_ADD;
            S_ADD:   state_d = S_SHIFT;
            // The counter value seen here is before this shift's increment.
            S_SHIFT: state_d = (cnt_inc == CW'(W)) ? S_FIN : S_ADD;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Booth add/subtract on the accumulator half; W-bit wrap is intended.
    always_comb begin
        a_new = a_cur;
        case (sr_dout[1:0])
            2'b01:   a_new = a_cur + m_q;
            2'b10:   a_new = a_cur - m_q;
            default: a_new = a_cur;
        endcase
    end

    // Output decode: shift-register strobes come purely from the state, so
    // load and shift can never overlap.
    always_comb begin
        sr_load  = 1'b0;
        sr_shren = 1'b0;
        sr_din   = 1'b0;
        sr_data  = '0;
        case (state_q)
            S_LOAD: begin
                sr_load = 1'b1;
                sr_data = {{W{1'b0}}, q_q, 1'b0};
            end
            S_ADD: begin
                sr_load = 1'b1;
                sr_data = {a_new, sr_dout[W:0]};
            end
            S_SHIFT: begin
                sr_shren = 1'b1;
                sr_din   = sr_dout[2*W];
            end
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        m_d       = m_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;
        if (accept) begin
            m_d    = multiplicand;
            q_d    = multiplier;
            busy_d = 1'b1;
        end
        if (state_q == S_LOAD) begin
            cnt_d = '0;
        end
        if (state_q == S_SHIFT) begin
            cnt_d = cnt_inc;
        end
        if (state_q == S_FIN) begin
            product_d = sr_dout[2*W:1];
            done_d    = 1'b1;
            busy_d    = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            m_q       <= m_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
module tb_booth_seq_ctrl;

    localparam int W   = 8;
    localparam int LAT = 2 * W + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [W-1:0]     multiplicand;
    logic [W-1:0]     multiplier;
    logic [2*W:0]     sr_dout;
    logic             sr_load;
    logic [2*W:0]     sr_data;
    logic             sr_shren;
    logic             sr_din;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    logic [2*W:0]     sr_q;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [2*W-1:0]   exp_prod_q[$];
    int               exp_cyc_q[$];
    logic             prev_done = 1'b0;

    booth_seq_ctrl #(.W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .sr_dout      (sr_dout),
        .sr_load      (sr_load),
        .sr_data      (sr_data),
        .sr_shren     (sr_shren),
        .sr_din       (sr_din),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    // Behavioural model of the external shift register: shift has priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          sr_q <= '0;
        else if (sr_shren) sr_q <= {sr_din, sr_q[2*W:1]};
        else if (sr_load)  sr_q <= sr_data;
    end
    assign sr_dout = sr_q;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input bit ok, input string name,
                                  input longint act, input longint req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endfunction

    // Reference: exact signed product truncated to 2W bits.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m,
                                               input logic [W-1:0] q);
        int mi;
        int qi;
        mi = int'($signed(m));
        qi = int'($signed(q));
        return (2*W)'(mi * qi);
    endfunction

    // Monitor: pops the scoreboard on each done pulse; also checks the
    // shift-register protocol every cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (sr_load && sr_shren)
                check(1'b0, "load_shift_overlap", 1, 0);
            if (sr_shren)
                check(sr_din == sr_dout[2*W], "sign_fill", sr_din, sr_dout[2*W]);
            if (done) begin
                check(!prev_done, "done_one_cycle", prev_done, 0);
                if (exp_prod_q.size() == 0) begin
                    check(1'b0, "unexpected_done", product, 0);
                end else begin
                    logic [2*W-1:0] ep;
                    int             ec;
                    ep = exp_prod_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check(product == ep, "product", product, ep);
                    check(cyc == ec, "done_latency", cyc, ec);
                    $display("[TB] done: product=0x%04h expected=0x%04h cycle=%0d", product, ep, cyc);
                end
            end
        end
        prev_done = done;
    end

    // Issue one operation from a negedge. inject_at: busy-cycle index at which
    // a spurious start is raised; abort_at: busy-cycle index at which reset
    // is dropped. Returns at the negedge of the done cycle (or after abort).
    task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q,
                          input int inject_at, input int abort_at);
        int cnt;
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        @(posedge clk);
        #1;
        start = 1'b0;
        check(busy == 1'b1, "busy_rise", busy, 1);
        exp_prod_q.push_back(ref_mul(m, q));
        exp_cyc_q.push_back(cyc + LAT);
        $display("[TB] issue: M=0x%02h Q=0x%02h expect=0x%04h", m, q, ref_mul(m, q));
        cnt = 0;
        for (int i = 0; i < LAT + 20; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            if (cnt == inject_at) begin
                start        = 1'b1;
                multiplicand = ~m;
                multiplier   = q + 8'd17;
            end else begin
                start = 1'b0;
            end
            if (cnt == abort_at) begin
                #2 rst = 1'b0;
                #1;
                check(busy == 1'b0, "rst_busy", busy, 0);
                check(done == 1'b0, "rst_done", done, 0);
                check(product == '0, "rst_product", product, 0);
                check({sr_load, sr_shren, sr_din} == 3'b000, "rst_sr_strobes",
                      {sr_load, sr_shren, sr_din}, 0);
                void'(exp_prod_q.pop_back());
                void'(exp_cyc_q.pop_back());
                $display("[TB] abort: reset asserted at busy cycle %0d", cnt);
                repeat (2) @(negedge clk);
                rst = 1'b1;
                repeat (30) @(negedge clk);
                check(busy == 1'b0, "idle_after_rst", busy, 0);
                check(product == '0, "product_after_rst", product, 0);
                return;
            end
        end
        start = 1'b0;
        check(cnt == LAT, "busy_length", cnt, LAT);
        check(done == 1'b1, "done_at_busy_fall", done, 1);
    endtask

    logic [W-1:0] dm [6] = '{8'h03, 8'hFD, 8'h7F, 8'hFF, 8'h7F, 8'h00};
    logic [W-1:0] dq [6] = '{8'h04, 8'h04, 8'h7F, 8'hFF, 8'h80, 8'h5A};

    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(negedge clk);
        check(busy == 1'b0, "reset_busy", busy, 0);
        check(done == 1'b0, "reset_done", done, 0);
        check(product == '0, "reset_product", product, 0);
        check({sr_load, sr_shren, sr_din} == 3'b000, "reset_sr", {sr_load, sr_shren, sr_din}, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Directed operand pairs
        for (int i = 0; i < 6; i++) begin
            run_op(dm[i], dq[i], 0, 0);
            @(negedge clk);
        end

        // Spurious start during a run must be ignored
        run_op(8'h15, 8'hE7, 5, 0);
        @(negedge clk);

        // Start in the done cycle starts a second run immediately
        run_op(8'h2B, 8'hC3, 0, 0);
        run_op(8'hF0, 8'h11, 0, 0);
        @(negedge clk);

        // Reset mid-operation
        run_op(8'h25, 8'h33, 0, 9);
        @(negedge clk);

        // Randomized operands with random idle gaps
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] m;
            logic [W-1:0] q;
            m = W'($urandom_range(0, 255));
            if (m == 8'h80) m = 8'h81;
            q = W'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(m, q, 0, 0);
            @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check(exp_prod_q.size() == 0, "scoreboard_empty", exp_prod_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
